// File: rtl/ram_upload_server.sv
// Streams console RAM bytes to the HPS upload port while holding the console CPU off the RAM port.
// Optional running checksum of RAM-sourced bytes is built only when UPLOAD_CHECKSUM_EN is defined.
module ram_upload_server #(
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                SIZE        = 65536,
  parameter int                RAM_LAT     = 1,
  parameter int                HOLD_CYCLES = 4,
  parameter logic [7:0]        FILL        = 8'hFF
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_q,
  output logic [16:0]       byte_cnt,
  output logic [7:0]        checksum
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_READY, S_WAIT} state_e;

  localparam logic [25:0] SIZE_W = 26'(SIZE);

  state_e            state_q, state_d;
  logic              upload_q;
  logic [15:0]       hold_cnt_q, hold_cnt_d;
  logic [1:0]        lat_cnt_q, lat_cnt_d;
  logic [7:0]        din_q, din_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [16:0]       byte_cnt_q, byte_cnt_d;
  logic              upload_rise;
  logic              in_range;

`ifdef UPLOAD_CHECKSUM_EN
  logic [7:0]        checksum_q, checksum_d;
`endif

  // upload_q resets low, so a level already high at reset release reads as a rise.
  assign upload_rise = ioctl_upload & ~upload_q;
  assign in_range    = {1'b0, ioctl_addr} < SIZE_W;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    din_d      = din_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    byte_cnt_d = byte_cnt_q;
`ifdef UPLOAD_CHECKSUM_EN
    checksum_d = checksum_q;
`endif

    // An upload fall outranks everything, including a coincident ioctl_rd.
    if (state_q != S_IDLE && !ioctl_upload) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (upload_rise) begin
            state_d    = S_HOLD;
            hold_cnt_d = 16'(HOLD_CYCLES - 1);
            byte_cnt_d = '0;
`ifdef UPLOAD_CHECKSUM_EN
            checksum_d = '0;
`endif
          end
        end
        S_HOLD: begin
          if (hold_cnt_q == 16'd0) state_d = S_READY;
          else                     hold_cnt_d = hold_cnt_q - 16'd1;
        end
        S_READY: begin
          if (ioctl_rd) begin
            if (in_range) begin
              mem_addr_d = BASE_ADDR + ioctl_addr[ADDR_W-1:0];
              mem_rd_d   = 1'b1;
              lat_cnt_d  = 2'(RAM_LAT);
              state_d    = S_WAIT;
            end else begin
              din_d = FILL;
            end
          end
        end
        S_WAIT: begin
          if (lat_cnt_q == 2'd0) begin
            din_d      = mem_q;
            byte_cnt_d = (byte_cnt_q == 17'h1FFFF) ? byte_cnt_q : byte_cnt_q + 17'd1;
`ifdef UPLOAD_CHECKSUM_EN
            checksum_d = checksum_q + mem_q;
`endif
            state_d    = S_READY;
          end else begin
            lat_cnt_d = lat_cnt_q - 2'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      upload_q   <= 1'b0;
      hold_cnt_q <= '0;
      lat_cnt_q  <= '0;
      din_q      <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      upload_q   <= ioctl_upload;
      hold_cnt_q <= hold_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      din_q      <= din_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

`ifdef UPLOAD_CHECKSUM_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) checksum_q <= '0;
    else          checksum_q <= checksum_d;
  end
  assign checksum = checksum_q;
`else
  assign checksum = 8'h00;
`endif

  // Status outputs decode straight from the state register.
  assign cpu_hold   = (state_q != S_IDLE);
  assign ioctl_wait = (state_q == S_HOLD) || (state_q == S_WAIT);
  assign ioctl_din  = din_q;
  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;
  assign byte_cnt   = byte_cnt_q;

endmodule
